periph_bus_arbiter: RTL

- Shares the single memory-mapped peripheral bus (timer and sibling peripherals) between two masters: M0 (CPU load/store unit) and M1 (DMA/debug).
- Drives the address / mem_write / mem_read / size / bidirectional 64-bit data bus that peripherals such as Timer_TS decode.
- Serialises requests with round-robin arbitration and runs one single-cycle bus access per grant.
- Returns read data and a done pulse to the granted master.

---
 rtl/periph_bus_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// periph_bus_arbiter
//
// Shares the single memory-mapped peripheral bus between two masters:
// M0 (CPU load/store unit) and M1 (DMA/debug). Requests are served one at a
// time with round-robin arbitration. Each grant runs exactly one bus access
// cycle (ACCESS), followed by a response cycle (RESP) that pulses the granted
// master's done and returns its read data.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   When defined, a master holding mX_lock with its request still set is
//   re-granted straight from RESP, up to MAX_LOCK re-grants in a row while
//   the other master waits. When undefined, the lock inputs are ignored and
//   arbitration is pure round-robin.
//
// Parameters:
//   ADDR_W    address width on master and bus sides
//   DATA_W    data width
//   MAX_LOCK  re-grants allowed to a locked master before a forced hand-over
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-low reset
//   mX_req         in   access request, level, held until mX_done
//   mX_lock        in   back-to-back ownership request (ARB_LOCK_EN only)
//   mX_addr        in   target address
//   mX_write       in   1 = write, 0 = read
//   mX_size        in   access size, passed through to the bus
//   mX_wdata       in   write data
//   mX_done        out  one-cycle completion pulse
//   mX_rdata       out  read data, valid with mX_done, held until next read
//   bus_address    out  peripheral address (0 when idle)
//   bus_mem_write  out  peripheral write strobe
//   bus_mem_read   out  peripheral read strobe
//   bus_size       out  access size (2'b11 when idle)
//   bus_data       io   driven with write data only during a write access
// ---------------------------------------------------------------------------
module periph_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int MAX_LOCK = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [1:0]        m0_size,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [1:0]        m1_size,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_mem_write,
    output logic              bus_mem_read,
    output logic [1:0]        bus_size,
    inout  wire  [DATA_W-1:0] bus_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic              gnt_q;      // master owning the access in flight
    logic              prio_q;     // master that wins a simultaneous request
    logic              wr_q;       // direction of the access in flight
    logic [DATA_W-1:0] wdata_q;    // write data held for the ACCESS cycle
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              rd_stb_q;
    logic              wr_stb_q;
    logic              done0_q;
    logic              done1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              start_d;    // a grant is issued at this edge
    logic              sel_d;      // master receiving that grant
    logic              oth_req;    // request of the master not currently granted

    assign oth_req = gnt_q ? m0_req : m1_req;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK + 1);

    logic [LCW-1:0]    lock_cnt_q;
    logic              own_req;
    logic              own_lock;
    logic              regrant_d;

    assign own_req  = gnt_q ? m1_req  : m0_req;
    assign own_lock = gnt_q ? m1_lock : m0_lock;
`else
    localparam int unused_max_lock = MAX_LOCK;
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
`endif

    // Grant decision. In RESP the granted master's own request is masked, so
    // only the other master (or, with locking, a locked owner) can be granted.
    always_comb begin
        start_d = 1'b0;
        sel_d   = prio_q;
`ifdef ARB_LOCK_EN
        regrant_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    start_d = 1'b1;
                    sel_d   = (m0_req && m1_req) ? prio_q : m1_req;
                end
            end
            RESP: begin
`ifdef ARB_LOCK_EN
                // A locked owner keeps the bus until it has used MAX_LOCK
                // re-grants while the other master is waiting.
                if (own_lock && own_req &&
                    !((lock_cnt_q == LCW'(MAX_LOCK)) && oth_req)) begin
                    start_d   = 1'b1;
                    sel_d     = gnt_q;
                    regrant_d = 1'b1;
                end else
`endif
                if (oth_req) begin
                    start_d = 1'b1;
                    sel_d   = ~gnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b11;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            // Bus and done default to idle; a grant below overrides the bus.
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b11;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;

            case (state_q)
                ACCESS: begin
                    state_q <= RESP;
                    if (gnt_q) begin
                        done1_q <= 1'b1;
                    end else begin
                        done0_q <= 1'b1;
                    end
                    // Peripherals drive bus_data combinationally during a
                    // read, so it is captured at the end of ACCESS.
                    if (!wr_q) begin
                        if (gnt_q) begin
                            rdata1_q <= bus_data;
                        end else begin
                            rdata0_q <= bus_data;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    prio_q  <= ~gnt_q;
                end
                default: state_q <= IDLE;
            endcase

            if (start_d) begin
                state_q  <= ACCESS;
                gnt_q    <= sel_d;
                wr_q     <= sel_d ? m1_write : m0_write;
                wdata_q  <= sel_d ? m1_wdata : m0_wdata;
                addr_q   <= sel_d ? m1_addr  : m0_addr;
                size_q   <= sel_d ? m1_size  : m0_size;
                rd_stb_q <= sel_d ? ~m1_write : ~m0_write;
                wr_stb_q <= sel_d ? m1_write  : m0_write;
            end

`ifdef ARB_LOCK_EN
            if (start_d) begin
                if (regrant_d) begin
                    if (lock_cnt_q != LCW'(MAX_LOCK)) begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end else if (sel_d != gnt_q) begin
                    lock_cnt_q <= '0;
                end
            end
`endif
        end
    end

    assign m0_done       = done0_q;
    assign m1_done       = done1_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign bus_address   = addr_q;
    assign bus_size      = size_q;
    assign bus_mem_read  = rd_stb_q;
    assign bus_mem_write = wr_stb_q;
    assign bus_data      = wr_stb_q ? wdata_q : {DATA_W{1'bz}};

endmodule
